// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and FSM state type for the program loader (LOADER_CHECKSUM_EN adds CHECK use)
package loader_pkg;

  localparam int WORD_W     = 16;
  localparam int FRAME_BITS = 18;

  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - memory write bus and status bundle of the loader (LOADER_CHECKSUM_EN adds checksum_bad)
interface program_loader_if;
  import loader_pkg::*;

  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_data;
  logic              mem_wren;
  logic              cpu_run;
  logic              load_error;
  logic [WORD_W-1:0] words_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic              checksum_bad;

  modport master (output mem_address, mem_data, mem_wren, cpu_run, load_error, words_loaded, checksum_bad);
  modport slave  (input  mem_address, mem_data, mem_wren, cpu_run, load_error, words_loaded, checksum_bad);
`else
  modport master (output mem_address, mem_data, mem_wren, cpu_run, load_error, words_loaded);
  modport slave  (input  mem_address, mem_data, mem_wren, cpu_run, load_error, words_loaded);
`endif

endinterface

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - synchronised bit-serial receiver of 16-bit words (start, 16 data LSB first, stop)
module serial_word_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_serial,
  input  logic              i_flush,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_shift;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_serial;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Bit-timing state machine: half-bit to mid-start, then one full bit period per sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (i_flush) begin
        r_state <= RX_IDLE;
      end else begin
        case (r_state)
          RX_IDLE: begin
            // edge was seen one cycle ago, so the half-bit wait is shortened by one
            if (!r_sync2 && r_prev) begin
              r_state <= RX_START;
              r_cnt   <= CNT_W'(CLKS_PER_BIT / 2 - 2);
            end
          end
          RX_START: begin
            if (r_cnt == '0) begin
              if (r_sync2) begin
                r_state <= RX_IDLE;
              end else begin
                r_state <= RX_BITS;
                r_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
                r_idx   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          RX_BITS: begin
            if (r_cnt == '0) begin
              r_shift <= {r_sync2, r_shift[WORD_W-1:1]};
              r_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
              if (r_idx == IDX_W'(FRAME_BITS - 3)) begin
                r_state <= RX_STOP;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          RX_STOP: begin
            if (r_cnt == '0) begin
              r_state <= RX_IDLE;
              if (r_sync2) begin
                o_word_valid <= 1'b1;
                o_word       <= r_shift;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a serial program image into memory and releases the CPU (optional LOADER_CHECKSUM_EN)
module program_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             restart,
  program_loader_if.master bus
);

  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic              w_frame_err;
  logic              w_restart_ok;
  logic [WORD_W-1:0] w_count_next;

  state_t            r_state;
  logic [WORD_W-1:0] r_n;
  logic [WORD_W-1:0] r_mem_address;
  logic [WORD_W-1:0] r_mem_data;
  logic              r_mem_wren;
  logic              r_cpu_run;
  logic              r_load_error;
  logic [WORD_W-1:0] r_words_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic              r_checksum_bad;
`endif

  // restart only re-arms from a finished or failed load; it also flushes the receiver
  assign w_restart_ok = restart && ((r_state == S_DONE) || (r_state == S_ERROR));
  assign w_count_next = r_words_loaded + 16'd1;

  serial_word_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_serial    (serial_in),
    .i_flush     (w_restart_ok),
    .o_word_valid(w_word_valid),
    .o_word      (w_word),
    .o_frame_err (w_frame_err)
  );

  assign bus.mem_address  = r_mem_address;
  assign bus.mem_data     = r_mem_data;
  assign bus.mem_wren     = r_mem_wren;
  assign bus.cpu_run      = r_cpu_run;
  assign bus.load_error   = r_load_error;
  assign bus.words_loaded = r_words_loaded;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum_bad = r_checksum_bad;
`endif

  // Load sequencer: header count, per-word write, completion/error with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_HEADER;
      r_n            <= '0;
      r_mem_address  <= BASE_ADDR;
      r_mem_data     <= '0;
      r_mem_wren     <= 1'b0;
      r_cpu_run      <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum          <= '0;
      r_checksum_bad <= 1'b0;
`endif
    end else begin
      r_mem_wren <= 1'b0;
      if (w_restart_ok) begin
        r_state        <= S_HEADER;
        r_cpu_run      <= 1'b0;
        r_load_error   <= 1'b0;
        r_words_loaded <= '0;
        r_mem_address  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        r_checksum_bad <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_HEADER: begin
            if (w_frame_err) begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
              r_cpu_run    <= 1'b0;
            end else if (w_word_valid) begin
              r_n <= w_word;
`ifdef LOADER_CHECKSUM_EN
              r_sum <= w_word;
`endif
              if (w_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state   <= S_DONE;
                r_cpu_run <= 1'b1;
`endif
              end else begin
                r_words_loaded <= '0;
                r_mem_address  <= BASE_ADDR;
                r_state        <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_frame_err) begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
              r_cpu_run    <= 1'b0;
            end else if (w_word_valid) begin
              r_mem_data <= w_word;
              r_mem_wren <= 1'b1;
              r_state    <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
              r_sum <= r_sum + w_word;
`endif
            end
          end
          S_WRITE: begin
            // a full frame is far longer than this cycle, so no word can arrive here
            r_words_loaded <= w_count_next;
            r_mem_address  <= r_mem_address + 16'd1;
            if (w_count_next == r_n) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CHECK;
`else
              r_state   <= S_DONE;
              r_cpu_run <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (w_frame_err) begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
              r_cpu_run    <= 1'b0;
            end else if (w_word_valid) begin
              if (w_word == r_sum) begin
                r_state   <= S_DONE;
                r_cpu_run <= 1'b1;
              end else begin
                r_state        <= S_ERROR;
                r_load_error   <= 1'b1;
                r_cpu_run      <= 1'b0;
                r_checksum_bad <= 1'b1;
              end
            end
          end
`endif
          S_DONE:  r_state <= S_DONE;
          S_ERROR: r_state <= S_ERROR;
          default: r_state <= S_HEADER;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader (covers LOADER_CHECKSUM_EN when defined)
module tb_program_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser1 = 1'b1;
  logic ser2 = 1'b1;
  logic restart1 = 1'b0;
  logic restart2 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  program_loader_if if1();
  program_loader_if if2();

  program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0010)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .serial_in(ser1), .restart(restart1), .bus(if1)
  );

  program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .serial_in(ser2), .restart(restart2), .bus(if2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // write monitor: pops the expected {address,data} for every mem_wren pulse
  always @(negedge clk) begin
    logic [31:0] e;
    if (if1.mem_wren) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write_dut1: got %h/%h expected none", if1.mem_address, if1.mem_data);
      end else begin
        e = q1.pop_front();
        chk("write_dut1", {if1.mem_address, if1.mem_data}, e);
      end
    end
    if (if2.mem_wren) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write_dut2: got %h/%h expected none", if2.mem_address, if2.mem_data);
      end else begin
        e = q2.pop_front();
        chk("write_dut2", {if2.mem_address, if2.mem_data}, e);
      end
    end
  end

  task automatic set_line(input int line, input logic b);
    if (line == 1) ser1 = b;
    else ser2 = b;
  endtask

  task automatic send_word(input int line, input logic [15:0] w, input logic stop);
    logic [17:0] f;
    f = {stop, w, 1'b0};
    for (int i = 0; i < 18; i++) begin
      set_line(line, f[i]);
      repeat (CPB) @(negedge clk);
    end
    set_line(line, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_restart1();
    @(negedge clk);
    restart1 = 1'b1;
    @(negedge clk);
    restart1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_addr", {16'h0, if1.mem_address}, 32'h0010);
    chk("reset_data", {16'h0, if1.mem_data}, 32'h0);
    chk("reset_wren", {31'h0, if1.mem_wren}, 32'h0);
    chk("reset_cpu_run", {31'h0, if1.cpu_run}, 32'h0);
    chk("reset_err", {31'h0, if1.load_error}, 32'h0);
    chk("reset_words", {16'h0, if1.words_loaded}, 32'h0);

    // load three words
    send_word(1, 16'h0003, 1'b1);
    q1.push_back({16'h0010, 16'h1234});
    q1.push_back({16'h0011, 16'hC0F5});
    q1.push_back({16'h0012, 16'hFFFF});
    send_word(1, 16'h1234, 1'b1);
    send_word(1, 16'hC0F5, 1'b1);
    send_word(1, 16'hFFFF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    chk("load3_wait_check", {31'h0, if1.cpu_run}, 32'h0);
    send_word(1, 16'hD32B, 1'b1);
`endif
    chk("load3_words", {16'h0, if1.words_loaded}, 32'h3);
    chk("load3_cpu_run", {31'h0, if1.cpu_run}, 32'h1);
    chk("load3_addr", {16'h0, if1.mem_address}, 32'h0013);

    // reset in the middle of a frame
    ser1 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr", {16'h0, if1.mem_address}, 32'h0010);
    chk("midrst_data", {16'h0, if1.mem_data}, 32'h0);
    chk("midrst_wren", {31'h0, if1.mem_wren}, 32'h0);
    chk("midrst_cpu_run", {31'h0, if1.cpu_run}, 32'h0);
    chk("midrst_err", {31'h0, if1.load_error}, 32'h0);
    chk("midrst_words", {16'h0, if1.words_loaded}, 32'h0);
    @(negedge clk);
    ser1 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // empty image
    send_word(1, 16'h0000, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    chk("n0_wait_check", {31'h0, if1.cpu_run}, 32'h0);
    send_word(1, 16'h0000, 1'b1);
`endif
    chk("n0_cpu_run", {31'h0, if1.cpu_run}, 32'h1);
    pulse_restart1();
    chk("n0_restart_cpu_run", {31'h0, if1.cpu_run}, 32'h0);

    // one-cycle glitch on the line
    @(negedge clk);
    #2 ser1 = 1'b0;
    #10 ser1 = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_err", {31'h0, if1.load_error}, 32'h0);
    chk("glitch_cpu_run", {31'h0, if1.cpu_run}, 32'h0);

    // framing error, then restart and reload
    send_word(1, 16'h0002, 1'b1);
    q1.push_back({16'h0010, 16'hAAAA});
    send_word(1, 16'hAAAA, 1'b1);
    send_word(1, 16'h1234, 1'b0);
    chk("ferr_err", {31'h0, if1.load_error}, 32'h1);
    chk("ferr_cpu_run", {31'h0, if1.cpu_run}, 32'h0);
    chk("ferr_words", {16'h0, if1.words_loaded}, 32'h1);
    pulse_restart1();
    chk("ferr_restart_err", {31'h0, if1.load_error}, 32'h0);
    chk("ferr_restart_words", {16'h0, if1.words_loaded}, 32'h0);
    send_word(1, 16'h0001, 1'b1);
    q1.push_back({16'h0010, 16'h5555});
    send_word(1, 16'h5555, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(1, 16'h5556, 1'b1);
`endif
    chk("reload_cpu_run", {31'h0, if1.cpu_run}, 32'h1);
    chk("reload_err", {31'h0, if1.load_error}, 32'h0);

    // restart while receiving data is ignored
    pulse_restart1();
    send_word(1, 16'h0001, 1'b1);
    pulse_restart1();
    q1.push_back({16'h0010, 16'h7777});
    send_word(1, 16'h7777, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(1, 16'h7778, 1'b1);
`endif
    chk("rsdata_cpu_run", {31'h0, if1.cpu_run}, 32'h1);
    chk("rsdata_words", {16'h0, if1.words_loaded}, 32'h1);

    // address wrap on the second instance
    send_word(2, 16'h0002, 1'b1);
    q2.push_back({16'hFFFF, 16'h1111});
    q2.push_back({16'h0000, 16'h2222});
    send_word(2, 16'h1111, 1'b1);
    send_word(2, 16'h2222, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(2, 16'h3335, 1'b1);
`endif
    chk("wrap_cpu_run", {31'h0, if2.cpu_run}, 32'h1);
    chk("wrap_addr", {16'h0, if2.mem_address}, 32'h0001);

`ifdef LOADER_CHECKSUM_EN
    pulse_restart1();
    send_word(1, 16'h0002, 1'b1);
    q1.push_back({16'h0010, 16'h0001});
    q1.push_back({16'h0011, 16'h0002});
    send_word(1, 16'h0001, 1'b1);
    send_word(1, 16'h0002, 1'b1);
    send_word(1, 16'h0005, 1'b1);
    chk("csum_ok_cpu_run", {31'h0, if1.cpu_run}, 32'h1);
    chk("csum_ok_bad", {31'h0, if1.checksum_bad}, 32'h0);
    pulse_restart1();
    send_word(1, 16'h0002, 1'b1);
    q1.push_back({16'h0010, 16'h0001});
    q1.push_back({16'h0011, 16'h0002});
    send_word(1, 16'h0001, 1'b1);
    send_word(1, 16'h0002, 1'b1);
    send_word(1, 16'h0006, 1'b1);
    chk("csum_bad_err", {31'h0, if1.load_error}, 32'h1);
    chk("csum_bad_flag", {31'h0, if1.checksum_bad}, 32'h1);
    chk("csum_bad_cpu_run", {31'h0, if1.cpu_run}, 32'h0);
    pulse_restart1();
    chk("csum_restart_flag", {31'h0, if1.checksum_bad}, 32'h0);
`endif

    repeat (20) @(negedge clk);
    chk("pending_writes_dut1", q1.size(), 32'h0);
    chk("pending_writes_dut2", q2.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writes a program image into the 16-bit instruction/data memory before the controller runs; the memory writer paired with the CPU's fetch/load reader.
- Receives bit-serial words on one input line in UART-style framing: a 16-bit word count N, then N words.
- Stores word i at BASE_ADDR+i through the memory write port, then releases the CPU with cpu_run.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=4, even)
- BASE_ADDR, 16'h0000, memory address of the first loaded word

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- serial_in  input  1  serial data line, idle high, asynchronous to clock
- restart  input  1  one-cycle pulse; re-arms loader from DONE or ERROR
- mem_address  output  16  memory write address
- mem_data  output  16  memory write data
- mem_wren  output  1  memory write enable, one-cycle pulse per word
- cpu_run  output  1  high while a complete image is loaded (CPU may fetch)
- load_error  output  1  high in ERROR state
- words_loaded  output  16  count of data words written in current load

Behaviour:
- Reset values (async, reset_n low): mem_address=BASE_ADDR, mem_data=0, mem_wren=0, cpu_run=0, load_error=0, words_loaded=0. Receiver idle; FSM in HEADER.
- Reset mid-load aborts immediately. Memory words already written stay as written.
- Input synchroniser:
  - serial_in passes through a 2-flop synchroniser; the synchronised value has a reset value of 1.
  - All timing below is measured from the synchronised signal.
- Word frame: start bit 0, then 16 data bits LSB first, then stop bit 1.
- Receiver timing:
  - A falling edge while idle starts a half-bit wait of CLKS_PER_BIT/2 cycles.
  - If the line reads 1 at mid-start, the edge is treated as a glitch and the receiver returns to idle with no error.
  - Otherwise each data bit is sampled every CLKS_PER_BIT cycles, then the stop bit.
  - Stop bit 0 is a framing error.
  - On a good stop bit, word_valid pulses for 1 cycle with the 16-bit word.
- FSM states: HEADER, DATA, WRITE, DONE, ERROR.
  - HEADER: on word_valid, latch N. If N=0, go to DONE. Else clear words_loaded, set mem_address=BASE_ADDR and go to DATA.
  - DATA: on word_valid, drive mem_data=word, go to WRITE.
  - WRITE (1 cycle): mem_wren=1 with stable mem_address/mem_data. Next cycle: words_loaded+1, mem_address+1 (wraps 16'hFFFF->16'h0000). Go to DONE if words_loaded+1==N, else DATA.
  - WRITE latency: last stop-bit sample to mem_wren is 2 cycles.
  - DONE: cpu_run=1. Further serial words are ignored.
  - ERROR: load_error=1, cpu_run=0. Entered on a framing error in any receiving state. Serial input is ignored.
- restart in DONE or ERROR:
  - Next state HEADER; cpu_run=0, load_error=0, words_loaded=0, mem_address=BASE_ADDR; receiver flushed to idle.
  - restart is ignored in other states.
  - If restart coincides with word_valid, restart wins and the word is discarded.
- Timing/back-pressure: the WRITE cycle always completes before the next word can finish (frame >= 72 cycles), so there is no back-pressure.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - After the N data words, one extra checksum word is received in a CHECK state (also used when N=0).
  - Required checksum = sum of N and all data words, mod 2^16.
  - Match goes to DONE; mismatch goes to ERROR. mem_wren is never asserted for the checksum word.
  - Also adds output checksum_bad (1 bit, reset 0). It is high in ERROR only when the error cause was a mismatch, and clears on restart.
- When undefined: no CHECK state and no checksum_bad port; the transition after the last word goes straight to DONE.

Decomposition:
- Package loader_pkg:
  - state enum (HEADER, DATA, WRITE, CHECK, DONE, ERROR)
  - WORD_W=16, FRAME_BITS=18 constants
- Sub-module serial_word_rx: synchroniser, bit-timing counter, shift register, word_valid/word/frame_err outputs, flush input.
- program_loader holds the FSM, address/count registers and checksum.

Test Plan:
All tests use CLKS_PER_BIT=4 and BASE_ADDR=16'h0010.
- Load 3 words:
  - Stimulus: send 0x0003, 0x1234, 0xC0F5, 0xFFFF.
  - Required: mem_wren pulses at 0x0010/0x0011/0x0012 with those data words; words_loaded=3; cpu_run=1 after the third write.
- N=0:
  - Stimulus: send 0x0000.
  - Required: no mem_wren; cpu_run=1. With the checksum feature, a further checksum word 0x0000 is needed before cpu_run=1.
- Framing error:
  - Stimulus: send 0x0002, 0xAAAA, then a frame with stop bit 0.
  - Required: load_error=1, cpu_run=0, words_loaded=1.
  - Then pulse restart and reload 0x0001, 0x5555: load_error=0, write 0x5555 at 0x0010, cpu_run=1.
- Glitch, reset and mid-frame restart:
  - 1-cycle low pulse on serial_in: no word, no error.
  - reset_n low mid-frame: all outputs return to reset values within the same cycle.
  - restart while in DATA: ignored.
- Address wrap:
  - Stimulus: BASE_ADDR=16'hFFFF, send 0x0002, 0x1111, 0x2222.
  - Required: writes at 0xFFFF then 0x0000.
- Checksum (LOADER_CHECKSUM_EN):
  - Stimulus: 0x0002, 0x0001, 0x0002, then 0x0005.
  - Required: cpu_run=1.
  - Same sequence with last word 0x0006: load_error=1, checksum_bad=1.
